// File: rtl/silu_act_sequencer.sv
// Feeds a stream of fp16 feature words, one at a time, through a shared Silumulti unit and
// returns each SiLU result on a valid/ready output. A job is cfg_len words.
module silu_act_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 4,
    parameter int LEN_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_start,
    input  logic [LEN_W-1:0]             cfg_len,
    output logic                         busy,
    output logic                         done,
    output logic                         err_timeout,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIZE*DATA_WIDTH-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIZE*DATA_WIDTH-1:0]   out_data,
    output logic [SIZE*DATA_WIDTH-1:0]   silu_x,
    output logic                         silu_reset,
    input  logic [SIZE*DATA_WIDTH-1:0]   silu_product,
    input  logic                         silu_finished
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               tmo_last;

    assign tmo_last = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: state_nxt = S_WAIT;
            S_WAIT: begin
                // A Finished arriving on the last allowed cycle still counts as success.
                if (silu_finished) begin
                    state_nxt = S_HOLD;
                end else if (tmo_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_nxt = (remaining == LEN_W'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining   <= '0;
            tmo_cnt     <= '0;
            silu_x      <= '0;
            out_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        remaining   <= cfg_len;
                        err_timeout <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        silu_x <= in_data;
                    end
                end
                S_LOAD: tmo_cnt <= '0;
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (silu_finished) begin
                        out_data <= silu_product;
                    end else if (tmo_last) begin
                        err_timeout <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and handshake outputs decode straight from the registered state.
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign in_ready   = (state == S_FETCH);
    assign out_valid  = (state == S_HOLD);
    assign silu_reset = reset | (state == S_LOAD);

endmodule

// File: tb/tb_silu_act_sequencer.sv
// Directed bench for silu_act_sequencer with a behavioural Silumulti whose product is ~x
// and whose Finished arrives a programmable number of cycles after the start pulse.
module tb_silu_act_sequencer;

    localparam int W = 64;

    logic          clk;
    logic          reset;
    logic          cfg_start;
    logic [15:0]   cfg_len;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [W-1:0]  silu_x;
    logic          silu_reset;
    logic [W-1:0]  silu_product;
    logic          silu_finished;

    silu_act_sequencer #(
        .DATA_WIDTH(16),
        .SIZE(4),
        .LEN_W(16),
        .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_start(cfg_start),
        .cfg_len(cfg_len),
        .busy(busy),
        .done(done),
        .err_timeout(err_timeout),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .silu_x(silu_x),
        .silu_reset(silu_reset),
        .silu_product(silu_product),
        .silu_finished(silu_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Silumulti stand-in
    logic        armed;
    int          fcnt;
    int          fin_delay;
    logic        never_fin;

    always @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            fcnt  <= 0;
        end else if (silu_reset) begin
            armed <= 1'b1;
            fcnt  <= 1;
        end else if (silu_finished) begin
            armed <= 1'b0;
        end else if (armed) begin
            fcnt <= fcnt + 1;
        end
    end

    assign silu_finished = armed && !never_fin && (fcnt == fin_delay);
    assign silu_product  = ~silu_x;

    // Event monitors, sampled mid-cycle
    int            pulse_cnt;
    int            done_cnt;
    int            rdy_cnt;
    logic [W-1:0]  out_q[$];

    initial begin
        pulse_cnt = 0;
        done_cnt  = 0;
        rdy_cnt   = 0;
    end

    always @(negedge clk) begin
        if (!reset && silu_reset) pulse_cnt++;
        if (done) done_cnt++;
        if (in_ready) rdy_cnt++;
        if (out_valid && out_ready) out_q.push_back(out_data);
    end

    int checks;
    int failures;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic start_job(input logic [15:0] len);
        cfg_len   = len;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] data);
        int guard;
        in_valid = 1'b1;
        in_data  = data;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (!in_ready) fail_now("in_ready_wait");
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Issue one word, measure handshake-to-out_valid latency, hold off out_ready for
    // 'hold' cycles, then accept the result.
    task automatic feed_word(input logic [W-1:0] data, input logic [W-1:0] exp,
                             input int hold, output int lat);
        send_word(data);
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        if (!out_valid) fail_now("out_valid_wait");
        chk("out_data", out_data, exp);
        chk("silu_x_stable", silu_x, data);
        for (int i = 0; i < hold; i++) begin
            chk("held_out_data", out_data, exp);
            chk("held_out_valid", 64'(out_valid), 64'd1);
            chk("held_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           delay;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t tv[4];

    initial begin
        int lat;
        int d0;
        int p0;
        int r0;
        int q0;
        logic [W-1:0] exp2[3];

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        fin_delay = 5;
        never_fin = 1'b0;

        tv[0] = '{64'h4000_3C00_9BDC_232F, 5,  64'hBFFF_C3FF_6423_DCD0, 7};
        tv[1] = '{64'h0000_0000_0000_0000, 1,  64'hFFFF_FFFF_FFFF_FFFF, 3};
        tv[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 64'h0000_0000_0000_0000, 66};
        tv[3] = '{64'h1234_5678_9ABC_DEF0, 3,  64'hEDCB_A987_6543_210F, 5};

        repeat (2) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_silu_x", silu_x, 64'd0);
        chk("rst_silu_reset", 64'(silu_reset), 64'd1);
        reset = 1'b0;
        step();
        chk("idle_silu_reset", 64'(silu_reset), 64'd0);

        // Single-word jobs, including Finished on the very last allowed WAIT cycle
        for (int i = 0; i < 4; i++) begin
            fin_delay = tv[i].delay;
            d0 = done_cnt;
            p0 = pulse_cnt;
            start_job(16'd1);
            chk("busy_after_start", 64'(busy), 64'd1);
            feed_word(tv[i].data, tv[i].exp, 0, lat);
            chk("latency", 64'(lat), 64'(tv[i].lat));
            chk("no_err", 64'(err_timeout), 64'd0);
            chk("done_pulse", 64'(done), 64'd1);
            step();
            chk("done_low", 64'(done), 64'd0);
            chk("busy_low", 64'(busy), 64'd0);
            chk("done_count", 64'(done_cnt - d0), 64'd1);
            chk("start_pulses", 64'(pulse_cnt - p0), 64'd1);
        end

        // Three back-to-back words with backpressure on the second
        fin_delay = 2;
        q0 = out_q.size();
        d0 = done_cnt;
        exp2[0] = 64'hFFFE_FFFD_FFFC_FFFB;
        exp2[1] = 64'h5555_AAAA_0F0F_F0F0;
        exp2[2] = 64'hC3FF_43FF_8400_FBFF;
        start_job(16'd3);
        feed_word(64'h0001_0002_0003_0004, exp2[0], 0, lat);
        feed_word(64'hAAAA_5555_F0F0_0F0F, exp2[1], 4, lat);
        feed_word(64'h3C00_BC00_7BFF_0400, exp2[2], 0, lat);
        chk("len3_done", 64'(done), 64'd1);
        step();
        chk("len3_done_count", 64'(done_cnt - d0), 64'd1);
        chk("len3_out_count", 64'(out_q.size() - q0), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (out_q.size() > q0 + i) chk("len3_order", out_q[q0 + i], exp2[i]);
            else fail_now("len3_order_missing");
        end

        // Zero-length job
        p0 = pulse_cnt;
        r0 = rdy_cnt;
        d0 = done_cnt;
        start_job(16'd0);
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_busy", 64'(busy), 64'd1);
        step();
        chk("len0_done_low", 64'(done), 64'd0);
        chk("len0_busy_low", 64'(busy), 64'd0);
        chk("len0_pulses", 64'(pulse_cnt - p0), 64'd0);
        chk("len0_ready", 64'(rdy_cnt - r0), 64'd0);
        chk("len0_done_count", 64'(done_cnt - d0), 64'd1);

        // Finished never arrives
        never_fin = 1'b1;
        q0 = out_q.size();
        start_job(16'd1);
        send_word(64'h0123_4567_89AB_CDEF);
        lat = 1;
        while (!done && lat < 300) begin
            step();
            lat++;
        end
        if (!done) fail_now("timeout_done_wait");
        chk("timeout_latency", 64'(lat), 64'd66);
        chk("timeout_err", 64'(err_timeout), 64'd1);
        chk("timeout_no_out", 64'(out_q.size() - q0), 64'd0);
        step();
        chk("timeout_busy_low", 64'(busy), 64'd0);
        chk("timeout_err_sticky", 64'(err_timeout), 64'd1);
        never_fin = 1'b0;
        start_job(16'd0);
        chk("err_cleared", 64'(err_timeout), 64'd0);
        step();

        // Asynchronous reset during WAIT of word 2 of 4
        fin_delay = 2;
        d0 = done_cnt;
        start_job(16'd4);
        feed_word(64'h1111_2222_3333_4444, 64'hEEEE_DDDD_CCCC_BBBB, 0, lat);
        fin_delay = 20;
        send_word(64'h5555_6666_7777_8888);
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", out_data, 64'd0);
        chk("mid_rst_silu_x", silu_x, 64'd0);
        chk("mid_rst_silu_reset", 64'(silu_reset), 64'd1);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd0);
        chk("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
        fin_delay = 2;

        // cfg_start while busy must not restart or resize the job
        d0 = done_cnt;
        q0 = out_q.size();
        start_job(16'd2);
        cfg_len   = 16'd5;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        feed_word(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 0, lat);
        cfg_start = 1'b1;
        feed_word(64'h8000_0001_8000_0001, 64'h7FFF_FFFE_7FFF_FFFE, 0, lat);
        cfg_start = 1'b0;
        chk("busy_start_done", 64'(done), 64'd1);
        step();
        chk("busy_start_idle", 64'(busy), 64'd0);
        chk("busy_start_done_count", 64'(done_cnt - d0), 64'd1);
        chk("busy_start_out_count", 64'(out_q.size() - q0), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
